bw_pred_regfile: RTL and testbench

- Predicate register file for the BlackWidow pipeline: 64 one-bit predicates; p0 reads constant 0, p1 reads constant 1.
- Supplies the registered-file value (prfo) that the predicate forwarding stage muxes against in-flight results.
- Accepts the writeback predicate pair from compare ops: pRt1 receives the result, pRt2 its complement.
- Provides a beat-serial save/restore engine for context switch and interrupt entry, with a valid/ready handshake.

---
 rtl/bw_pred_regfile_pkg.sv | 17 +
 rtl/bw_pred_serdes.sv | 127 ++++++++++++
 rtl/bw_pred_regfile.sv | 87 ++++++++
 tb/tb_bw_pred_regfile.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bw_pred_regfile_pkg.sv
// Shared types and default sizing for the BlackWidow predicate register file.
package bw_pred_regfile_pkg;

    localparam int NPRED       = 64;
    localparam int PRED_BEAT_W = 8;
    localparam int PRED_PRW    = $clog2(NPRED);

    typedef logic [PRED_PRW-1:0] pred_idx_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2,
        COMMIT  = 2'd3
    } pred_fsm_t;

endpackage

// File: rtl/bw_pred_serdes.sv
// Beat-serial save/restore engine: FSM, beat counter, save snapshot and restore shadow.
module bw_pred_serdes #(
    parameter int NPRED  = 64,
    parameter int BEAT_W = 8,
    parameter int PRW    = $clog2(NPRED)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NPRED-1:0]  snap_src,
    input  logic              save_req,
    input  logic              restore_req,
    output logic [BEAT_W-1:0] sv_dat,
    output logic              sv_vld,
    input  logic              sv_rdy,
    input  logic [BEAT_W-1:0] rs_dat,
    input  logic              rs_vld,
    output logic              rs_rdy,
    output logic              busy,
    output logic              done,
    output logic [NPRED-1:0]  shadow,
    output logic              commit
);
    import bw_pred_regfile_pkg::*;

    localparam int NBEAT  = NPRED / BEAT_W;
    localparam int CW     = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int BW_LOG = $clog2(BEAT_W);

    pred_fsm_t         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NPRED-1:0]  snap_q, snap_d;
    logic [NPRED-1:0]  shadow_q, shadow_d;
    logic [BEAT_W-1:0] sv_dat_q, sv_dat_d;
    logic              sv_vld_q, rs_rdy_q, busy_q, done_q, done_d;
    logic              last_beat;
    logic [PRW-1:0]    wr_base, rd_base;

    // Beat index within the NPRED-bit vector; BEAT_W divides a power of two, so a shift suffices.
    assign last_beat = (cnt_q == CW'(NBEAT - 1));
    assign wr_base   = PRW'({cnt_q, {BW_LOG{1'b0}}});
    assign rd_base   = PRW'({cnt_d, {BW_LOG{1'b0}}});

    // Next-state, counter, snapshot/shadow capture and registered-output precompute.
    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        snap_d   = snap_q;
        shadow_d = shadow_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (save_req) begin
                    state_d = SAVE;
                    snap_d  = snap_src;
                    cnt_d   = '0;
                end else if (restore_req) begin
                    state_d = RESTORE;
                    cnt_d   = '0;
                end
            end
            SAVE: begin
                if (sv_vld_q && sv_rdy) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESTORE: begin
                if (rs_vld && rs_rdy_q) begin
                    shadow_d[wr_base +: BEAT_W] = rs_dat;
                    if (last_beat) begin
                        state_d = COMMIT;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        sv_dat_d = (state_d == SAVE) ? snap_d[rd_base +: BEAT_W] : '0;
    end

    // State, counter, snapshot/shadow and the registered handshake outputs.
    // NOTE: snapshot and shadow are plain flop vectors, so they take the async reset like any state;
    // that is what guarantees a partial shadow cannot survive a mid-restore reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            snap_q   <= '0;
            shadow_q <= '0;
            sv_dat_q <= '0;
            sv_vld_q <= 1'b0;
            rs_rdy_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            shadow_q <= shadow_d;
            sv_dat_q <= sv_dat_d;
            sv_vld_q <= (state_d == SAVE);
            rs_rdy_q <= (state_d == RESTORE);
            busy_q   <= (state_d != IDLE);
            done_q   <= done_d;
        end
    end

    assign sv_dat = sv_dat_q;
    assign sv_vld = sv_vld_q;
    assign rs_rdy = rs_rdy_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign shadow = shadow_q;
    assign commit = (state_q == COMMIT);

endmodule

// File: rtl/bw_pred_regfile.sv
// BlackWidow predicate register file: storage, three read ports, writeback pair and save/restore engine.
module bw_pred_regfile #(
    parameter int NPRED  = bw_pred_regfile_pkg::NPRED,
    parameter int BEAT_W = bw_pred_regfile_pkg::PRED_BEAT_W,
    parameter int PRW    = $clog2(NPRED)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PRW-1:0]    pRa,
    input  logic [PRW-1:0]    pRb,
    input  logic [PRW-1:0]    pRc,
    output logic              prfoa,
    output logic              prfob,
    output logic              prfoc,
    input  logic              wprfwr,
    input  logic [PRW-1:0]    wpRt1,
    input  logic [PRW-1:0]    wpRt2,
    input  logic              wpres,
    input  logic              save_req,
    input  logic              restore_req,
    output logic [BEAT_W-1:0] sv_dat,
    output logic              sv_vld,
    input  logic              sv_rdy,
    input  logic [BEAT_W-1:0] rs_dat,
    input  logic              rs_vld,
    output logic              rs_rdy,
    output logic              busy,
    output logic              done
);
    import bw_pred_regfile_pkg::*;

    logic [NPRED-1:0] storage_q, storage_d;
    logic [NPRED-1:0] shadow;
    logic             commit;

    // Write arbitration: commit overrides writeback; wpRt1 is applied last so it wins on a collision;
    // p0/p1 are pinned so writes to them are dropped.
    always_comb begin
        storage_d = storage_q;
        if (commit) begin
            storage_d = shadow;
        end else if (wprfwr) begin
            storage_d[wpRt2] = ~wpres;
            storage_d[wpRt1] = wpres;
        end
        storage_d[0] = 1'b0;
        storage_d[1] = 1'b1;
    end

    // Predicate storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            storage_q <= NPRED'(2'b10);
        end else begin
            storage_q <= storage_d;
        end
    end

    // Combinational reads with constant p0/p1; no write-to-read bypass.
    assign prfoa = (pRa == PRW'(0)) ? 1'b0 : (pRa == PRW'(1)) ? 1'b1 : storage_q[pRa];
    assign prfob = (pRb == PRW'(0)) ? 1'b0 : (pRb == PRW'(1)) ? 1'b1 : storage_q[pRb];
    assign prfoc = (pRc == PRW'(0)) ? 1'b0 : (pRc == PRW'(1)) ? 1'b1 : storage_q[pRc];

    // The snapshot source is storage_d so a write in the save_req cycle is captured.
    bw_pred_serdes #(
        .NPRED  (NPRED),
        .BEAT_W (BEAT_W),
        .PRW    (PRW)
    ) u_serdes (
        .clk         (clk),
        .rst_n       (rst_n),
        .snap_src    (storage_d),
        .save_req    (save_req),
        .restore_req (restore_req),
        .sv_dat      (sv_dat),
        .sv_vld      (sv_vld),
        .sv_rdy      (sv_rdy),
        .rs_dat      (rs_dat),
        .rs_vld      (rs_vld),
        .rs_rdy      (rs_rdy),
        .busy        (busy),
        .done        (done),
        .shadow      (shadow),
        .commit      (commit)
    );

endmodule

// File: tb/tb_bw_pred_regfile.sv
// Directed self-checking bench for bw_pred_regfile.
module tb_bw_pred_regfile;

    localparam int NPRED  = 64;
    localparam int BEAT_W = 8;
    localparam int PRW    = 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PRW-1:0]    pRa, pRb, pRc;
    logic              prfoa, prfob, prfoc;
    logic              wprfwr;
    logic [PRW-1:0]    wpRt1, wpRt2;
    logic              wpres;
    logic              save_req, restore_req;
    logic [BEAT_W-1:0] sv_dat;
    logic              sv_vld, sv_rdy;
    logic [BEAT_W-1:0] rs_dat;
    logic              rs_vld, rs_rdy;
    logic              busy, done;

    int n_pass   = 0;
    int n_total  = 0;
    int done_cnt = 0;
    int beat;
    logic [7:0] exp_beat [8];

    bw_pred_regfile #(.NPRED(NPRED), .BEAT_W(BEAT_W), .PRW(PRW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pRa(pRa), .pRb(pRb), .pRc(pRc),
        .prfoa(prfoa), .prfob(prfob), .prfoc(prfoc),
        .wprfwr(wprfwr), .wpRt1(wpRt1), .wpRt2(wpRt2), .wpres(wpres),
        .save_req(save_req), .restore_req(restore_req),
        .sv_dat(sv_dat), .sv_vld(sv_vld), .sv_rdy(sv_rdy),
        .rs_dat(rs_dat), .rs_vld(rs_vld), .rs_rdy(rs_rdy),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wr(input int t1, input int t2, input logic res);
        @(negedge clk);
        wprfwr = 1'b1; wpRt1 = PRW'(t1); wpRt2 = PRW'(t2); wpres = res;
        @(negedge clk);
        wprfwr = 1'b0;
    endtask

    task automatic rd(input string tag, input int idx, input logic exp);
        pRa = PRW'(idx);
        #1;
        check(tag, prfoa, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; pRa = '0; pRb = '0; pRc = '0;
        wprfwr = 1'b0; wpRt1 = '0; wpRt2 = '0; wpres = 1'b0;
        save_req = 1'b0; restore_req = 1'b0; sv_rdy = 1'b0;
        rs_dat = '0; rs_vld = 1'b0;
        exp_beat = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Post-reset state
        pRa = 6'd0; pRb = 6'd1; pRc = 6'd2;
        #1;
        check("rst_p0", prfoa, 1'b0);
        check("rst_p1", prfob, 1'b1);
        check("rst_p2", prfoc, 1'b0);
        rd("rst_p63", 63, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sv_vld", sv_vld, 1'b0);
        check("rst_rs_rdy", rs_rdy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sv_dat", sv_dat, 8'h00);

        // Writeback pair
        wr(5, 6, 1'b1);
        rd("wr_p5", 5, 1'b1);
        rd("wr_p6", 6, 1'b0);
        wr(9, 10, 1'b1);
        rd("wr_p9_set", 9, 1'b1);
        wr(9, 9, 1'b0);
        rd("wr_same_t1_wins", 9, 1'b0);
        wr(1, 0, 1'b0);
        rd("wr_p0_drop", 0, 1'b0);
        rd("wr_p1_drop", 1, 1'b1);
        wr(0, 1, 1'b0);
        rd("wr_p0_drop2", 0, 1'b0);
        rd("wr_p1_drop2", 1, 1'b1);
        wr(6, 5, 1'b1);
        wr(2, 6, 1'b1);
        rd("wr_p2", 2, 1'b1);
        rd("wr_p5_clr", 5, 1'b0);
        rd("wr_p6_clr", 6, 1'b0);

        // Save with p63 written in the request cycle and sv_rdy toggling
        @(negedge clk);
        save_req = 1'b1;
        wprfwr = 1'b1; wpRt1 = 6'd63; wpRt2 = 6'd8; wpres = 1'b1;
        @(negedge clk);
        save_req = 1'b0; wprfwr = 1'b0;
        rd("save_p63", 63, 1'b1);
        check("save_busy", busy, 1'b1);
        beat = 0;
        for (int cyc = 0; cyc < 64 && beat < 8; cyc++) begin
            check("save_vld", sv_vld, 1'b1);
            check($sformatf("save_beat%0d", beat), sv_dat, exp_beat[beat]);
            check("save_no_done", done, 1'b0);
            if (cyc == 0) begin
                wprfwr = 1'b1; wpRt1 = 6'd11; wpRt2 = 6'd12; wpres = 1'b1;
            end else begin
                wprfwr = 1'b0;
            end
            sv_rdy = cyc[0];
            if (sv_rdy) beat++;
            @(negedge clk);
        end
        wprfwr = 1'b0; sv_rdy = 1'b0;
        check("save_beats", beat, 8);
        check("save_done", done, 1'b1);
        check("save_busy_fall", busy, 1'b0);
        check("save_vld_fall", sv_vld, 1'b0);
        @(negedge clk);
        check("save_done_pulse", done, 1'b0);
        rd("save_wr_p11", 11, 1'b1);
        rd("save_wr_p12", 12, 1'b0);

        // Restore of all-ones with rs_vld gaps, a save_req during RESTORE, and a write during COMMIT
        @(negedge clk);
        done_cnt = 0;
        restore_req = 1'b1;
        @(negedge clk);
        restore_req = 1'b0;
        check("rst_req_rdy", rs_rdy, 1'b1);
        check("rst_req_busy", busy, 1'b1);
        beat = 0;
        for (int cyc = 0; cyc < 64 && beat < 8; cyc++) begin
            check("restore_no_save", sv_vld, 1'b0);
            check("restore_no_done", done, 1'b0);
            rs_vld   = ((cyc % 3) != 1);
            rs_dat   = 8'hFF;
            save_req = (cyc == 2);
            if (rs_vld && rs_rdy) beat++;
            @(negedge clk);
        end
        rs_vld = 1'b0; save_req = 1'b0;
        wprfwr = 1'b1; wpRt1 = 6'd4; wpRt2 = 6'd5; wpres = 1'b0;
        check("restore_beats", beat, 8);
        check("commit_busy", busy, 1'b1);
        check("commit_done", done, 1'b1);
        check("commit_rs_rdy", rs_rdy, 1'b0);
        @(negedge clk);
        wprfwr = 1'b0;
        check("commit_done_fall", done, 1'b0);
        check("commit_busy_fall", busy, 1'b0);
        check("restore_save_ignored", sv_vld, 1'b0);
        rd("commit_p0", 0, 1'b0);
        rd("commit_p1", 1, 1'b1);
        for (int i = 2; i < NPRED; i++) rd($sformatf("commit_p%0d", i), i, 1'b1);
        check("restore_done_once", done_cnt, 1);

        // Simultaneous requests: save wins
        @(negedge clk);
        save_req = 1'b1; restore_req = 1'b1;
        @(negedge clk);
        save_req = 1'b0; restore_req = 1'b0;
        check("both_sv_vld", sv_vld, 1'b1);
        check("both_rs_rdy", rs_rdy, 1'b0);
        check("both_beat0", sv_dat, 8'hFE);
        sv_rdy = 1'b1;
        for (int cyc = 0; cyc < 20 && busy; cyc++) @(negedge clk);
        sv_rdy = 1'b0;
        check("both_save_end", busy, 1'b0);
        @(negedge clk);
        check("both_no_restore", rs_rdy, 1'b0);
        check("both_idle", busy, 1'b0);

        // Reset after three restore beats
        done_cnt = 0;
        restore_req = 1'b1;
        @(negedge clk);
        restore_req = 1'b0;
        rs_dat = 8'hAA; rs_vld = 1'b1;
        repeat (3) @(negedge clk);
        rs_vld = 1'b0;
        check("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_rs_rdy", rs_rdy, 1'b0);
        check("mid_done", done, 1'b0);
        rd("mid_p2", 2, 1'b0);
        rd("mid_p63", 63, 1'b0);
        rd("mid_p1", 1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("mid_no_commit_done", done_cnt, 0);
        check("mid_idle", busy, 1'b0);
        rd("mid_after_p2", 2, 1'b0);
        rd("mid_after_p4", 4, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
